// File: rtl/sm2_pmul_issuer.sv
// Job sequencer for the SM2 point-multiplication engine: scalar checks, engine reset/start, timeout, response.
// Optional scalar reduction (k >= n -> k - n) enabled by defining SM2_PMUL_KREDUCE_EN.
module sm2_pmul_issuer #(
    parameter int                WIDTH          = 256,
    parameter logic [WIDTH-1:0]  N_ORDER        = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123,
    parameter int                HOLD_CYCLES    = 2,
    parameter logic [23:0]       TIMEOUT_CYCLES = 24'd4000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_k,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             eng_rst_n,
    output logic [WIDTH-1:0] eng_k,
    output logic [WIDTH-1:0] eng_x,
    output logic [WIDTH-1:0] eng_y,
    input  logic [WIDTH-1:0] eng_x_out,
    input  logic [WIDTH-1:0] eng_y_out,
    input  logic             eng_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_x,
    output logic [WIDTH-1:0] rsp_y,
    output logic [1:0]       rsp_err
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_HOLD, S_RUN, S_RESP} state_t;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_ZERO = 2'd1;
    localparam logic [1:0] ERR_BIG  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    state_t      state, state_nx;
    logic [3:0]  hold_cnt;
    logic [23:0] tmo_cnt;
    logic        k_zero, k_big, hold_last, tmo_last, accept, rsp_hs;
    logic        chk_fail;

    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign k_zero    = (eng_k == '0);
    assign k_big     = (eng_k >= N_ORDER);
    assign hold_last = (hold_cnt == 4'(HOLD_CYCLES - 1));
    assign tmo_last  = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);

`ifdef SM2_PMUL_KREDUCE_EN
    // Two-step CHECK: reduce first, then zero-test the reduced scalar (k == n lands on zero).
    logic chk_ph;
    logic chk_done;
    assign chk_done = chk_ph;
    assign chk_fail = k_zero;
`else
    logic chk_done;
    assign chk_done = 1'b1;
    assign chk_fail = k_zero || k_big;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_CHECK;
            S_CHECK: if (chk_done) state_nx = chk_fail ? S_RESP : S_HOLD;
            S_HOLD:  if (hold_last) state_nx = S_RUN;
            S_RUN:   if (eng_done || tmo_last) state_nx = S_RESP;
            S_RESP:  if (rsp_hs) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // All outputs are registered; updates are keyed off the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            eng_rst_n <= 1'b0;
            eng_k     <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            rsp_valid <= 1'b0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_err   <= ERR_OK;
            hold_cnt  <= '0;
            tmo_cnt   <= '0;
`ifdef SM2_PMUL_KREDUCE_EN
            chk_ph    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        eng_k     <= req_k;
                        eng_x     <= req_x;
                        eng_y     <= req_y;
                        req_ready <= 1'b0;
                        hold_cnt  <= '0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_CHECK: begin
`ifdef SM2_PMUL_KREDUCE_EN
                    if (!chk_ph) begin
                        chk_ph <= 1'b1;
                        if (k_big) eng_k <= eng_k - N_ORDER;
                    end else begin
                        chk_ph <= 1'b0;
                        if (k_zero) begin
                            rsp_err   <= ERR_ZERO;
                            rsp_x     <= '0;
                            rsp_y     <= '0;
                            rsp_valid <= 1'b1;
                        end
                    end
`else
                    if (k_zero || k_big) begin
                        rsp_err   <= k_zero ? ERR_ZERO : ERR_BIG;
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_valid <= 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (hold_last) begin
                        eng_rst_n <= 1'b1;
                        tmo_cnt   <= '0;
                    end else begin
                        hold_cnt  <= hold_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    if (eng_done) begin
                        rsp_x     <= eng_x_out;
                        rsp_y     <= eng_y_out;
                        rsp_err   <= ERR_OK;
                        eng_rst_n <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (tmo_last) begin
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_err   <= ERR_TMO;
                        eng_rst_n <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 24'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm2_pmul_issuer.sv
// Directed bench for sm2_pmul_issuer with a stub engine that answers k=1 and k=n-1 only.
module tb_sm2_pmul_issuer;

    localparam int          W    = 256;
    localparam logic [W-1:0] N   = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123;
    localparam logic [W-1:0] P   = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [W-1:0] GX  = 256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [W-1:0] GY  = 256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
    localparam logic [W-1:0] GYN = P - GY;
    localparam int HOLD    = 2;
    localparam int TMO     = 1000;
    localparam int ENG_LAT = 5;
`ifdef SM2_PMUL_KREDUCE_EN
    localparam int CHK_CYC = 2;
`else
    localparam int CHK_CYC = 1;
`endif

    logic clk, rst_n;
    logic req_valid, req_ready, eng_rst_n, eng_done, rsp_valid, rsp_ready;
    logic [W-1:0] req_k, req_x, req_y, eng_k, eng_x, eng_y, eng_x_out, eng_y_out, rsp_x, rsp_y;
    logic [1:0] rsp_err;
    logic done_force;
    logic [7:0] ecnt;
    logic known;

    int total = 0;
    int bad   = 0;

    sm2_pmul_issuer #(.WIDTH(W), .N_ORDER(N), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(24'(TMO))) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_k(req_k), .req_x(req_x), .req_y(req_y),
        .eng_rst_n(eng_rst_n), .eng_k(eng_k), .eng_x(eng_x), .eng_y(eng_y),
        .eng_x_out(eng_x_out), .eng_y_out(eng_y_out), .eng_done(eng_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub engine: done level rises ENG_LAT cycles after release for the two scalars it knows.
    always_ff @(posedge clk) begin
        if (!eng_rst_n)         ecnt <= '0;
        else if (ecnt != 8'hff) ecnt <= ecnt + 8'd1;
    end
    assign known     = (eng_k == 256'd1) || (eng_k == N - 256'd1);
    assign eng_done  = (eng_rst_n && known && ecnt >= 8'(ENG_LAT)) || done_force;
    assign eng_x_out = GX;
    assign eng_y_out = (eng_k == 256'd1) ? GY : GYN;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Issue one job and wait for rsp_valid; cycle counts are negedges after the accept edge.
    task automatic run_job(input logic [W-1:0] k, input logic [W-1:0] x, input logic [W-1:0] y,
                           output int rsp_cyc, output int rise_cyc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_k = k; req_x = x; req_y = y;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_ready wait", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_cyc = 1; rise_cyc = 0;
        while (!rsp_valid && rsp_cyc < 3000) begin
            if (eng_rst_n && rise_cyc == 0) rise_cyc = rsp_cyc;
            @(negedge clk);
            rsp_cyc++;
        end
        if (!rsp_valid) chk("rsp_valid wait", 0, 1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid after hs", 256'(rsp_valid), 0);
        chk("req_ready after hs", 256'(req_ready), 1);
    endtask

    initial begin
        int rc, rr, n;
        logic stable;
        logic [W-1:0] sx, sy;
        logic [1:0] se;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; done_force = 1'b0;
        req_k = '0; req_x = '0; req_y = '0;
        repeat (3) @(negedge clk);
        chk("rst req_ready", 256'(req_ready), 0);
        chk("rst eng_rst_n", 256'(eng_rst_n), 0);
        chk("rst rsp_valid", 256'(rsp_valid), 0);
        chk("rst rsp_x", rsp_x, 0);
        chk("rst eng_k", eng_k, 0);
        chk("rst rsp_err", 256'(rsp_err), 0);
        rst_n = 1'b1;

        // done asserted while idle must not produce anything
        done_force = 1'b1;
        repeat (4) @(negedge clk);
        done_force = 1'b0;
        chk("idle done rsp_valid", 256'(rsp_valid), 0);
        chk("idle done eng_rst_n", 256'(eng_rst_n), 0);

        run_job(256'd1, GX, GY, rc, rr);
        chk("k1 err", 256'(rsp_err), 0);
        chk("k1 x", rsp_x, GX);
        chk("k1 y", rsp_y, GY);
        chk("k1 hold len", 256'(rr), 256'(1 + CHK_CYC + HOLD));
        chk("k1 run len", 256'(rc - rr), 256'(ENG_LAT + 1));
        chk("k1 eng_rst_n low", 256'(eng_rst_n), 0);
        take_rsp();

        run_job(N - 256'd1, GX, GY, rc, rr);
        chk("kn-1 err", 256'(rsp_err), 0);
        chk("kn-1 x", rsp_x, GX);
        chk("kn-1 y", rsp_y, GYN);
        take_rsp();

        run_job(256'd0, GX, GY, rc, rr);
        chk("k0 err", 256'(rsp_err), 1);
        chk("k0 x", rsp_x, 0);
        chk("k0 y", rsp_y, 0);
        chk("k0 latency", 256'(rc), 256'(1 + CHK_CYC));
        chk("k0 eng never up", 256'(rr), 0);
        take_rsp();

        run_job(N, GX, GY, rc, rr);
`ifdef SM2_PMUL_KREDUCE_EN
        chk("kn err", 256'(rsp_err), 1);
`else
        chk("kn err", 256'(rsp_err), 2);
`endif
        chk("kn x", rsp_x, 0);
        chk("kn eng never up", 256'(rr), 0);
        take_rsp();

        run_job(N + 256'd1, GX, GY, rc, rr);
`ifdef SM2_PMUL_KREDUCE_EN
        chk("kn+1 err", 256'(rsp_err), 0);
        chk("kn+1 x", rsp_x, GX);
        chk("kn+1 y", rsp_y, GY);
`else
        chk("kn+1 err", 256'(rsp_err), 2);
        chk("kn+1 x", rsp_x, 0);
`endif
        take_rsp();

        // k=2 is unknown to the stub, so the job must time out
        run_job(256'd2, GX, GY, rc, rr);
        chk("tmo err", 256'(rsp_err), 3);
        chk("tmo x", rsp_x, 0);
        chk("tmo y", rsp_y, 0);
        chk("tmo run len", 256'(rc - rr), 256'(TMO));
        chk("tmo eng_rst_n low", 256'(eng_rst_n), 0);

        // stall the response ten cycles
        sx = rsp_x; sy = rsp_y; se = rsp_err; stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_x !== sx || rsp_y !== sy || rsp_err !== se || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("stall stable", 256'(stable), 1);
        take_rsp();

        // reset in the middle of RUN
        @(negedge clk);
        req_valid = 1'b1; req_k = 256'd2; req_x = GX; req_y = GY;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!eng_rst_n && n < 50) begin @(negedge clk); n++; end
        chk("mid eng up", 256'(eng_rst_n), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst eng_rst_n", 256'(eng_rst_n), 0);
        chk("mid rst rsp_valid", 256'(rsp_valid), 0);
        chk("mid rst req_ready", 256'(req_ready), 0);
        chk("mid rst eng_k", eng_k, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(256'd1, GX, GY, rc, rr);
        chk("post rst err", 256'(rsp_err), 0);
        chk("post rst x", rsp_x, GX);
        chk("post rst y", rsp_y, GY);
        take_rsp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
